// File: rtl/ife_pkg.sv
// Shared types and constants for the instruction-fetch block builder and block queue.
package ife_pkg;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    localparam int unsigned BLK_ID_W    = 8;
    localparam int unsigned BLK_INSTR_W = 32;
    localparam int unsigned BLK_SIZE    = 4;

    // Block payload exchanged between builder and queue (default geometry).
    typedef struct packed {
        logic [BLK_ID_W-1:0]                     id;
        logic [BLK_SIZE-1:0][BLK_INSTR_W-1:0]    slots;
    } block_t;

endpackage

// File: rtl/ife_block_builder.sv
// Packs a serial instruction stream into fixed-size, ID-tagged blocks.
// A flush closes a partial block early and pads the unused slots with NOPs.
module ife_block_builder
    import ife_pkg::*;
#(
    parameter int unsigned     BLOCK_ID_WIDTH = 8,
    parameter int unsigned     INSTR_WIDTH    = 32,
    parameter int unsigned     BLOCK_SIZE     = 4,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = INSTR_WIDTH'(NOP_INSTR_DEFAULT)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [INSTR_WIDTH-1:0]               instr_in,
    input  logic                                 instr_valid,
    output logic                                 instr_ready,
    input  logic                                 flush,
    output logic [BLOCK_ID_WIDTH-1:0]            block_id_out,
    output logic [BLOCK_SIZE*INSTR_WIDTH-1:0]    block_out,
    output logic                                 valid_out,
    input  logic                                 ready_downstream,
    output logic [$clog2(BLOCK_SIZE+1)-1:0]      fill_level
);

    localparam int unsigned FILL_W = $clog2(BLOCK_SIZE + 1);
    localparam logic [FILL_W-1:0] LAST_SLOT = FILL_W'(BLOCK_SIZE - 1);

    state_t              state;
    logic                accept_c;
    logic                close_c;
    logic [FILL_W-1:0]   fill_next_c;

    assign accept_c    = instr_valid && instr_ready && (state == FILL);
    assign fill_next_c = fill_level + FILL_W'(accept_c);
    // Block closes on the accept that fills the last slot, or on a flush with something to send.
    assign close_c     = (accept_c && (fill_level == LAST_SLOT))
                       || (flush && ((fill_level != '0) || accept_c));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FILL;
            fill_level   <= '0;
            block_id_out <= '0;
            valid_out    <= 1'b0;
            instr_ready  <= 1'b0;
            for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
                block_out[i*INSTR_WIDTH +: INSTR_WIDTH] <= NOP_INSTR;
            end
        end else begin
            unique case (state)
                FILL: begin
                    if (accept_c) begin
                        block_out[32'(fill_level)*INSTR_WIDTH +: INSTR_WIDTH] <= instr_in;
                        fill_level <= fill_next_c;
                    end
                    if (close_c) begin
                        // Pad everything past the last real instruction; a full block pads nothing.
                        for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
                            if (i >= 32'(fill_next_c)) begin
                                block_out[i*INSTR_WIDTH +: INSTR_WIDTH] <= NOP_INSTR;
                            end
                        end
                        state       <= EMIT;
                        valid_out   <= 1'b1;
                        instr_ready <= 1'b0;
                    end else begin
                        instr_ready <= 1'b1;
                    end
                end
                EMIT: begin
                    if (ready_downstream) begin
                        block_id_out <= block_id_out + BLOCK_ID_WIDTH'(1);
                        fill_level   <= '0;
                        state        <= FILL;
                        valid_out    <= 1'b0;
                        instr_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ife_block_builder.sv
// Directed self-checking bench for ife_block_builder with default parameters.
module tb_ife_block_builder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  instr_in;
    logic         instr_valid;
    logic         instr_ready;
    logic         flush;
    logic [7:0]   block_id_out;
    logic [127:0] block_out;
    logic         valid_out;
    logic         ready_downstream;
    logic [2:0]   fill_level;

    int checks = 0;
    int errors = 0;

    ife_block_builder dut (
        .clk              (clk),
        .rst              (rst),
        .instr_in         (instr_in),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .flush            (flush),
        .block_id_out     (block_id_out),
        .block_out        (block_out),
        .valid_out        (valid_out),
        .ready_downstream (ready_downstream),
        .fill_level       (fill_level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] blk(input logic [31:0] s0, input logic [31:0] s1,
                                         input logic [31:0] s2, input logic [31:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic send(input logic [31:0] v);
        instr_valid = 1'b1;
        instr_in    = v;
        step();
        instr_valid = 1'b0;
    endtask

    logic [127:0] held;

    initial begin
        rst = 1'b1; instr_in = '0; instr_valid = 1'b0; flush = 1'b0; ready_downstream = 1'b1;
        step(); step();
        chk("rst_ready", 128'(instr_ready), 128'(0));
        chk("rst_valid", 128'(valid_out), 128'(0));
        rst = 1'b0;
        step();
        chk("init_ready", 128'(instr_ready), 128'(1));
        chk("init_valid", 128'(valid_out), 128'(0));
        chk("init_fill", 128'(fill_level), 128'(0));
        chk("init_id", 128'(block_id_out), 128'(0));
        chk("init_block", block_out, blk(NOP, NOP, NOP, NOP));

        // Basic fill
        send(32'h11); send(32'h22); send(32'h33);
        chk("fill3_valid", 128'(valid_out), 128'(0));
        send(32'h44);
        chk("basic_valid", 128'(valid_out), 128'(1));
        chk("basic_ready", 128'(instr_ready), 128'(0));
        chk("basic_block", block_out, blk(32'h11, 32'h22, 32'h33, 32'h44));
        chk("basic_id", 128'(block_id_out), 128'(0));
        chk("basic_fill", 128'(fill_level), 128'(4));
        step();
        chk("basic_one_cycle", 128'(valid_out), 128'(0));
        chk("basic_next_id", 128'(block_id_out), 128'(1));
        chk("basic_fill_clr", 128'(fill_level), 128'(0));

        // Backpressure with an instruction waiting
        ready_downstream = 1'b0;
        send(32'h1); send(32'h2); send(32'h3); send(32'h4);
        held = blk(32'h1, 32'h2, 32'h3, 32'h4);
        instr_valid = 1'b1; instr_in = 32'h55;
        for (int i = 0; i < 6; i++) begin
            chk("bp_valid", 128'(valid_out), 128'(1));
            chk("bp_block", block_out, held);
            chk("bp_id", 128'(block_id_out), 128'(1));
            chk("bp_ready", 128'(instr_ready), 128'(0));
            chk("bp_fill", 128'(fill_level), 128'(4));
            step();
        end
        ready_downstream = 1'b1;
        step();
        chk("bp_release_valid", 128'(valid_out), 128'(0));
        chk("bp_release_id", 128'(block_id_out), 128'(2));
        step();
        instr_valid = 1'b0;
        chk("bp_held_fill", 128'(fill_level), 128'(1));
        send(32'h66); send(32'h77); send(32'h88);
        chk("bp_held_block", block_out, blk(32'h55, 32'h66, 32'h77, 32'h88));
        chk("bp_held_valid", 128'(valid_out), 128'(1));
        step();

        // Flush after a partial block
        send(32'hA); send(32'hB);
        flush = 1'b1; step(); flush = 1'b0;
        chk("flush_valid", 128'(valid_out), 128'(1));
        chk("flush_block", block_out, blk(32'hA, 32'hB, NOP, NOP));
        chk("flush_fill", 128'(fill_level), 128'(2));
        chk("flush_id", 128'(block_id_out), 128'(3));
        step();

        // Flush coincident with the second accept
        send(32'hA);
        flush = 1'b1; send(32'hB); flush = 1'b0;
        chk("cflush_valid", 128'(valid_out), 128'(1));
        chk("cflush_block", block_out, blk(32'hA, 32'hB, NOP, NOP));
        chk("cflush_fill", 128'(fill_level), 128'(2));
        chk("cflush_id", 128'(block_id_out), 128'(4));
        step();

        // Flush on an empty block is ignored
        flush = 1'b1; step(); flush = 1'b0;
        chk("eflush_valid", 128'(valid_out), 128'(0));
        chk("eflush_id", 128'(block_id_out), 128'(5));
        chk("eflush_fill", 128'(fill_level), 128'(0));
        step();
        chk("eflush_valid2", 128'(valid_out), 128'(0));

        // Flush during EMIT is ignored
        ready_downstream = 1'b0;
        send(32'hC1); send(32'hC2); send(32'hC3); send(32'hC4);
        flush = 1'b1; step(); flush = 1'b0;
        chk("mflush_valid", 128'(valid_out), 128'(1));
        chk("mflush_block", block_out, blk(32'hC1, 32'hC2, 32'hC3, 32'hC4));
        chk("mflush_fill", 128'(fill_level), 128'(4));
        ready_downstream = 1'b1;
        step();
        chk("mflush_done", 128'(valid_out), 128'(0));
        chk("mflush_id", 128'(block_id_out), 128'(6));
        step();
        chk("mflush_no_extra", 128'(valid_out), 128'(0));

        // Reset while a block is presented and stalled
        ready_downstream = 1'b0;
        send(32'hD1); send(32'hD2); send(32'hD3); send(32'hD4);
        chk("mrst_pre_valid", 128'(valid_out), 128'(1));
        rst = 1'b1; step(); rst = 1'b0;
        chk("mrst_valid", 128'(valid_out), 128'(0));
        chk("mrst_fill", 128'(fill_level), 128'(0));
        chk("mrst_id", 128'(block_id_out), 128'(0));
        chk("mrst_block", block_out, blk(NOP, NOP, NOP, NOP));
        ready_downstream = 1'b1;
        step();

        // 257 blocks: IDs 0..255 then wrap to 0
        for (int k = 0; k < 257; k++) begin
            for (int j = 0; j < 4; j++) send(32'(k * 4 + j));
            chk("wrap_valid", 128'(valid_out), 128'(1));
            chk("wrap_id", 128'(block_id_out), 128'(k % 256));
            chk("wrap_block", block_out,
                blk(32'(k * 4), 32'(k * 4 + 1), 32'(k * 4 + 2), 32'(k * 4 + 3)));
            step();
        end
        chk("wrap_final_id", 128'(block_id_out), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ife_block_builder.md
# ife_block_builder

Upstream stage of the instruction-block queue. Accepts a serial stream of instructions, one per cycle over valid/ready, and packs them into fixed-size blocks of BLOCK_SIZE slots. Tags each block with a monotonically increasing block ID and presents it on a valid/ready port that connects directly to the queue's block input. A flush input closes a partially filled block early and pads the unused slots with NOPs, so every emitted block is always full width.

## Interface

Parameters:
- BLOCK_ID_WIDTH, 8, width of the block tag; the tag wraps modulo 2^BLOCK_ID_WIDTH.
- INSTR_WIDTH, 32, width of one instruction.
- BLOCK_SIZE, 4, instructions per block; must be ≥ 2.
- NOP_INSTR, 32'h0000_0013, pad value for unfilled slots.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- instr_in  in  INSTR_WIDTH  incoming instruction.
- instr_valid  in  1  instr_in is valid.
- instr_ready  out  1  builder can accept an instruction this cycle.
- flush  in  1  close the current partial block (single-cycle pulse).
- block_id_out  out  BLOCK_ID_WIDTH  tag of the presented block.
- block_out  out  BLOCK_SIZE×INSTR_WIDTH (packed)  block contents; slot 0 holds the oldest instruction.
- valid_out  out  1  a block is presented.
- ready_downstream  in  1  consumer accepts the block.
- fill_level  out  $clog2(BLOCK_SIZE+1)  number of real instructions captured in the current block.

## Operation

- Two states, FILL and EMIT, held in one state register. Reset state is FILL.
- FILL:
  - instr_ready=1 and valid_out=0.
  - An accept is instr_valid && instr_ready. On accept, write slot[fill_level] and increment fill_level.
  - If an accept fills the last slot (fill_level==BLOCK_SIZE-1), go to EMIT.
  - If flush=1 and (fill_level>0 or an accept occurs in the same cycle):
    - include that cycle's accepted instruction, if any;
    - write NOP_INSTR into every remaining slot;
    - go to EMIT.
  - If flush=1 with fill_level==0 and no accept, the flush is ignored and no empty block is emitted.
  - A flush that coincides with the accept that completes the block needs no padding; the result is identical to that accept alone.
- EMIT:
  - instr_ready=0 and valid_out=1.
  - block_out, block_id_out and fill_level are held stable until the handshake.
  - When ready_downstream=1:
    - the block transfers;
    - the ID counter increments, wrapping 2^W-1→0;
    - fill_level clears to 0;
    - the state returns to FILL.
  - flush is ignored in EMIT.
- instr_ready and valid_out decode only from the state register, with no combinational path from any input.
- The consumer may hold ready_downstream low indefinitely. No instruction is dropped or duplicated.

## Timing

- Reset values:
  - state=FILL, fill_level=0, ID counter=0;
  - block_id_out=0, every block_out slot=NOP_INSTR;
  - valid_out=0, instr_ready=1 from the first cycle after reset is released.
- While rst=1, instr_ready=0 and valid_out=0.
- Latency: valid_out rises on the cycle after the accept that completes the block, or after the flush edge.
- Throughput: one block per BLOCK_SIZE+1 cycles at best, because there is one EMIT cycle and no fill/emit overlap.
- Reset asserted mid-operation, in either state, discards the partial or presented block and restores all reset values on the next edge.

## Structure

- ife_pkg holds:
  - the state enum type (FILL, EMIT);
  - the default NOP constant;
  - the shared block type, a packed struct of ID plus slot array, which the queue also uses.
- Single module. Slot storage, the fill counter, the ID counter and the FSM are all inline. No sub-module is warranted.

## Test plan

- Basic fill:
  - Stimulus: after reset, stream 0x11, 0x22, 0x33, 0x44 back-to-back with ready_downstream=1.
  - Required: valid_out high for exactly one cycle after the 4th accept, with block_out slots 0..3 = 11, 22, 33, 44, block_id_out=0 and fill_level=4.
  - The next block carries ID 1.
- Backpressure:
  - Stimulus: hold ready_downstream=0 for 6 cycles while a block is presented, with instr_valid held high.
  - Required: valid_out stays 1, block and ID are unchanged, instr_ready=0 and no instruction is consumed.
  - After ready returns, the held instruction lands in slot 0 of the next block.
- Flush partial:
  - Stimulus: accept 0xA, 0xB, then pulse flush.
  - Required: block slots = A, B, NOP, NOP and fill_level=2.
  - Repeat with flush coincident with the accept of 0xB; the result must be identical.
- Flush corner cases:
  - Flush with fill_level=0 → no block emitted and the ID is unchanged.
  - Flush during EMIT → ignored.
- ID wrap: emit 257 blocks → IDs run 0..255, then 0.
- Reset mid-EMIT:
  - Stimulus: assert rst while valid_out=1 and ready_downstream=0.
  - Required: next cycle valid_out=0, fill_level=0, and the next emitted block has ID 0.
